des_key_schedule: RTL and testbench

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

---
 rtl/des_pkg.sv | 57 +++++
 rtl/des_key_schedule_if.sv | 24 ++
 rtl/des_pc2.sv | 20 ++
 rtl/des_key_schedule.sv | 125 ++++++++++++
 tb/tb_des_key_schedule.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// DES key-schedule constants shared by the schedule and its PC-2 stage:
// selection tables, rotation schedule, FSM encoding and bit helpers.
package des_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ks_state_e;

    // Tables hold 1-based DES bit numbers; bit 1 is the MSB of the source vector.
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_TBL [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[55 - i] = key[64 - PC1_TBL[i]];
        end
        return cd;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Every key byte must carry an odd number of ones.
    function automatic logic key_parity_ok(input logic [63:0] key);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (^key[b*8 +: 8] == 1'b0) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-in / subkey-out handshake bundle of the DES key schedule.
// slave = the schedule itself, master = key source and subkey consumer.
interface des_key_schedule_if;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key;
    logic        decrypt;
    logic        sk_valid;
    logic        sk_ready;
    logic [47:0] sk;
    logic [3:0]  sk_round;
    logic        sk_last;
    logic        key_err;

    modport master (
        output key_valid, key, decrypt, sk_ready,
        input  key_ready, sk_valid, sk, sk_round, sk_last, key_err
    );

    modport slave (
        input  key_valid, key, decrypt, sk_ready,
        output key_ready, sk_valid, sk, sk_round, sk_last, key_err
    );
endinterface

// File: rtl/des_pc2.sv
// PC-2 compression: selects the 48 subkey bits from the 56-bit C||D register pair.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] sk
);

    // PC-2 discards CD bits 9, 18, 22, 25, 35, 38, 43 and 54.
    logic unused_cd_bits;
    assign unused_cd_bits = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

    always_comb begin
        sk = '0;
        for (int i = 0; i < 48; i++) begin
            sk[47 - i] = cd[56 - PC2_TBL[i]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 on key acceptance, one PC-2 subkey per sk handshake.
// Define DES_KS_DECRYPT_EN to build the K16..K1 (decrypt) order; otherwise encrypt order only.
module des_key_schedule
    import des_pkg::*;
#(
    parameter int PARITY_CHK = 0
) (
    input logic               clk,
    input logic               rst,
    des_key_schedule_if.slave bus
);

    localparam logic [0:0] IDLE = ST_IDLE;
    localparam logic [0:0] RUN  = ST_RUN;

    logic [0:0]  state_q, state_d;
    logic [27:0] c_half_q, c_half_d;
    logic [27:0] d_half_q, d_half_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        key_err_q, key_err_d;
    logic        accept;
    logic        advance;
    logic [55:0] cd0;

`ifdef DES_KS_DECRYPT_EN
    logic dec_q, dec_d;
`else
    logic unused_decrypt;
    assign unused_decrypt = bus.decrypt;
`endif

    assign accept  = (state_q == IDLE) && bus.key_valid;
    assign advance = (state_q == RUN) && bus.sk_ready;
    assign cd0     = pc1(bus.key);

    // NOTE: every _d signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        c_half_d  = c_half_q;
        d_half_d  = d_half_q;
        cnt_d     = cnt_q;
        key_err_d = key_err_q;
`ifdef DES_KS_DECRYPT_EN
        dec_d     = dec_q;
`endif
        if (accept) begin
            state_d   = RUN;
            cnt_d     = '0;
            key_err_d = (PARITY_CHK != 0) && !key_parity_ok(bus.key);
`ifdef DES_KS_DECRYPT_EN
            dec_d = bus.decrypt;
            // K16 has a cumulative rotation of 28, i.e. the unrotated PC-1 halves.
            if (bus.decrypt) begin
                c_half_d = cd0[55:28];
                d_half_d = cd0[27:0];
            end else begin
                c_half_d = rotl(cd0[55:28], SHIFT_TBL[0]);
                d_half_d = rotl(cd0[27:0], SHIFT_TBL[0]);
            end
`else
            c_half_d = rotl(cd0[55:28], SHIFT_TBL[0]);
            d_half_d = rotl(cd0[27:0], SHIFT_TBL[0]);
`endif
        end else if (advance) begin
            if (cnt_q == 4'd15) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 4'd1;
`ifdef DES_KS_DECRYPT_EN
                if (dec_q) begin
                    // Undo the rotation that produced the subkey just consumed.
                    c_half_d = rotr(c_half_q, SHIFT_TBL[4'd15 - cnt_q]);
                    d_half_d = rotr(d_half_q, SHIFT_TBL[4'd15 - cnt_q]);
                end else begin
                    c_half_d = rotl(c_half_q, SHIFT_TBL[cnt_q + 4'd1]);
                    d_half_d = rotl(d_half_q, SHIFT_TBL[cnt_q + 4'd1]);
                end
`else
                c_half_d = rotl(c_half_q, SHIFT_TBL[cnt_q + 4'd1]);
                d_half_d = rotl(d_half_q, SHIFT_TBL[cnt_q + 4'd1]);
`endif
            end
        end
    end

    // NOTE: state registers use <= so every flop samples pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            c_half_q  <= '0;
            d_half_q  <= '0;
            cnt_q     <= '0;
            key_err_q <= 1'b0;
`ifdef DES_KS_DECRYPT_EN
            dec_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            c_half_q  <= c_half_d;
            d_half_q  <= d_half_d;
            cnt_q     <= cnt_d;
            key_err_q <= key_err_d;
`ifdef DES_KS_DECRYPT_EN
            dec_q     <= dec_d;
`endif
        end
    end

    assign bus.key_ready = (state_q == IDLE);
    assign bus.sk_valid  = (state_q == RUN);
    assign bus.sk_last   = (cnt_q == 4'd15);
    assign bus.key_err   = key_err_q;
`ifdef DES_KS_DECRYPT_EN
    assign bus.sk_round  = dec_q ? (4'd15 - cnt_q) : cnt_q;
`else
    assign bus.sk_round  = cnt_q;
`endif

    des_pc2 u_pc2 (
        .cd ({c_half_q, d_half_q}),
        .sk (bus.sk)
    );

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: key table plus a subkey scoreboard,
// with hand-written backpressure, mid-run reset and key-held-in-RUN sequences.
module tb_des_key_schedule;

    typedef struct packed {
        logic [63:0] key;
        logic        dec;
        logic        perr;
        logic        use_ref;
        logic [47:0] pat;
    } vec_t;

    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  round;
        logic        last;
    } exp_t;

    // Published subkeys K1..K16 of key 0x133457799BBCDFF1.
    localparam logic [47:0] KREF [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q [$];
    exp_t mon_e;
    vec_t vecs [7];

    des_key_schedule_if if0 ();
    des_key_schedule_if if1 ();

    assign if1.key_valid = if0.key_valid;
    assign if1.key       = if0.key;
    assign if1.decrypt   = if0.decrypt;
    assign if1.sk_ready  = if0.sk_ready;

    des_key_schedule #(.PARITY_CHK(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    des_key_schedule #(.PARITY_CHK(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Scoreboard: every handshaken subkey is compared against the next queued entry.
    always @(negedge clk) begin
        if (!rst && if0.sk_valid && if0.sk_ready) begin
            if (exp_q.size() == 0) begin
                check("sk_unexpected", {63'd0, if0.sk_valid}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sk", {16'd0, if0.sk}, {16'd0, mon_e.sk});
                check("sk_par", {16'd0, if1.sk}, {16'd0, mon_e.sk});
                check("sk_round", {60'd0, if0.sk_round}, {60'd0, mon_e.round});
                check("sk_last", {63'd0, if0.sk_last}, {63'd0, mon_e.last});
            end
        end
    end

    function automatic void push_exp(input vec_t v);
        for (int r = 0; r < 16; r++) begin
            exp_t e;
            int   rd;
            rd = r;
`ifdef DES_KS_DECRYPT_EN
            if (v.dec) rd = 15 - r;
`endif
            e.sk    = v.use_ref ? KREF[rd] : v.pat;
            e.round = 4'(rd);
            e.last  = (r == 15);
            exp_q.push_back(e);
        end
    endfunction

    // Returns #1 after the accepting edge; key_valid stays up only when keep is set.
    task automatic offer_key(input logic [63:0] k, input logic dec, input bit keep, output bit ok);
        if0.key       = k;
        if0.decrypt   = dec;
        if0.key_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (if0.key_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        if (!keep) if0.key_valid = 1'b0;
        if (!ok) timeout("key_accept");
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            timeout("drain");
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        check("ready_after_last", {63'd0, if0.key_ready}, 64'd1);
        check("valid_after_last", {63'd0, if0.sk_valid}, 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        offer_key(v.key, v.dec, 1'b0, ok);
        if (ok) begin
            push_exp(v);
            check("first_valid", {63'd0, if0.sk_valid}, 64'd1);
            check("key_err_nochk", {63'd0, if0.key_err}, 64'd0);
            check("key_err_chk", {63'd0, if1.key_err}, {63'd0, v.perr});
            wait_drain();
        end
    endtask

    task automatic wait_round(input logic [3:0] rnd, output bit found);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (if0.sk_valid && if0.sk_round == rnd) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!found) timeout("wait_round");
    endtask

    initial begin
        bit ok;
        vecs[0] = '{key: 64'h133457799BBCDFF1, dec: 1'b0, perr: 1'b0, use_ref: 1'b1, pat: 48'h0};
        vecs[1] = '{key: 64'h133457799BBCDFF1, dec: 1'b1, perr: 1'b0, use_ref: 1'b1, pat: 48'h0};
        vecs[2] = '{key: 64'h133457799BBCDFF0, dec: 1'b0, perr: 1'b1, use_ref: 1'b1, pat: 48'h0};
        vecs[3] = '{key: 64'h0101010101010101, dec: 1'b0, perr: 1'b0, use_ref: 1'b0, pat: 48'h000000000000};
        vecs[4] = '{key: 64'hFEFEFEFEFEFEFEFE, dec: 1'b1, perr: 1'b0, use_ref: 1'b0, pat: 48'hFFFFFFFFFFFF};
        vecs[5] = '{key: 64'h1F1F1F1F0E0E0E0E, dec: 1'b0, perr: 1'b0, use_ref: 1'b0, pat: 48'h000000FFFFFF};
        vecs[6] = '{key: 64'hE0E0E0E0F1F1F1F1, dec: 1'b0, perr: 1'b0, use_ref: 1'b0, pat: 48'hFFFFFF000000};

        rst           = 1'b1;
        if0.key_valid = 1'b0;
        if0.key       = '0;
        if0.decrypt   = 1'b0;
        if0.sk_ready  = 1'b1;
        #1;
        check("rst_sk_valid", {63'd0, if0.sk_valid}, 64'd0);
        check("rst_sk_last", {63'd0, if0.sk_last}, 64'd0);
        check("rst_sk_round", {60'd0, if0.sk_round}, 64'd0);
        check("rst_sk", {16'd0, if0.sk}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", {63'd0, if0.key_ready}, 64'd1);
        check("post_rst_key_err", {63'd0, if1.key_err}, 64'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Backpressure: hold round 3 for five cycles.
        offer_key(vecs[0].key, 1'b0, 1'b0, ok);
        if (ok) begin
            push_exp(vecs[0]);
            wait_round(4'd3, ok);
            if0.sk_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                check("stall_valid", {63'd0, if0.sk_valid}, 64'd1);
                check("stall_sk", {16'd0, if0.sk}, {16'd0, KREF[3]});
                check("stall_round", {60'd0, if0.sk_round}, 64'd3);
            end
            if0.sk_ready = 1'b1;
            wait_drain();
        end

        // Asynchronous reset in the middle of round 7.
        offer_key(vecs[0].key, 1'b0, 1'b0, ok);
        if (ok) begin
            push_exp(vecs[0]);
            wait_round(4'd7, ok);
            rst = 1'b1;
            #1;
            check("midrst_valid", {63'd0, if0.sk_valid}, 64'd0);
            check("midrst_sk", {16'd0, if0.sk}, 64'd0);
            check("midrst_round", {60'd0, if0.sk_round}, 64'd0);
            exp_q.delete();
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            @(posedge clk);
            #1;
            check("midrst_ready", {63'd0, if0.key_ready}, 64'd1);
            run_vec(vecs[0]);
        end

        // A second key held on key_valid throughout RUN is taken only once IDLE returns.
        offer_key(vecs[0].key, 1'b0, 1'b1, ok);
        if (ok) begin
            push_exp(vecs[0]);
            if0.key = vecs[5].key;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                check("busy_ready", {63'd0, if0.key_ready}, 64'd0);
            end
            offer_key(vecs[5].key, 1'b0, 1'b0, ok);
            if (ok) begin
                push_exp(vecs[5]);
                check("held_key_valid", {63'd0, if0.sk_valid}, 64'd1);
                check("held_key_round", {60'd0, if0.sk_round}, 64'd0);
                wait_drain();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
